// File: rtl/uart_autobaud_detect.sv
// Measures the bit period of an incoming 0x55 sync character on a raw RX line
// and reports the clock-cycles-per-bit divisor for the baud generator.
module uart_autobaud_detect #(
    parameter int CLK_RATE    = 150000000,
    parameter int MIN_BAUD    = 1200,
    parameter int MAX_BAUD    = 921600,
    parameter int SYNC_STAGES = 2,
    localparam int MAX_DIV    = CLK_RATE / MIN_BAUD,
    localparam int MIN_DIV    = CLK_RATE / MAX_BAUD,
    localparam int TMO        = 9 * MAX_DIV,
    localparam int CNT_W      = $clog2(TMO + 1),
    localparam int DIV_W      = $clog2(MAX_DIV + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_rx,
    input  logic             i_arm,
    output logic             o_busy,
    output logic             o_valid,
    output logic [DIV_W-1:0] o_divisor,
    output logic             o_err,
    output logic [1:0]       o_err_code
);
    typedef enum logic [1:0] {S_IDLE, S_HUNT, S_MEAS} state_t;

    localparam logic [CNT_W-1:0] TMO_C     = CNT_W'(TMO);
    localparam logic [DIV_W-1:0] MIN_DIV_C = DIV_W'(MIN_DIV);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rx_prev;
    logic                   r_fall;
    logic                   w_rx_s;

    state_t           r_state, w_state_nx;
    logic [CNT_W-1:0] r_total, w_total_nx;
    logic [CNT_W-1:0] r_intv,  w_intv_nx;
    logic [CNT_W-1:0] r_i0,    w_i0_nx;
    logic [2:0]       r_edges, w_edges_nx;
    logic             r_seen,  w_seen_nx;
    logic             r_valid, w_valid_nx;
    logic             r_err,   w_err_nx;
    logic [1:0]       r_code,  w_code_nx;
    logic [DIV_W-1:0] r_div,   w_div_nx;

    logic [CNT_W-1:0] w_tot, w_int, w_diff;
    logic [CNT_W:0]   w_sum;
    logic [DIV_W-1:0] w_div;
    logic             w_bad;

    assign w_rx_s = r_sync[SYNC_STAGES-1];

    // Sync flops preset to idle-high so reset never fabricates a falling edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync    <= '1;
            r_rx_prev <= 1'b1;
            r_fall    <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], i_rx};
            r_rx_prev <= w_rx_s;
            r_fall    <= r_rx_prev & ~w_rx_s;
        end
    end

    assign w_tot  = (r_total == TMO_C) ? TMO_C : r_total + 1'b1;
    assign w_int  = (r_intv  == TMO_C) ? TMO_C : r_intv  + 1'b1;
    assign w_diff = (w_int >= r_i0) ? w_int - r_i0 : r_i0 - w_int;
    assign w_bad  = w_diff > (r_i0 >> 2);
    assign w_sum  = {1'b0, w_tot} + (CNT_W+1)'(4);
    assign w_div  = DIV_W'(w_sum >> 3);

    always_comb begin
        w_state_nx = r_state;
        w_total_nx = r_total;
        w_intv_nx  = r_intv;
        w_i0_nx    = r_i0;
        w_edges_nx = r_edges;
        w_seen_nx  = r_seen;
        w_valid_nx = 1'b0;
        w_err_nx   = 1'b0;
        w_code_nx  = r_code;
        w_div_nx   = r_div;
        case (r_state)
            S_IDLE: begin
                if (i_arm) begin
                    w_state_nx = S_HUNT;
                    w_seen_nx  = 1'b0;
                end
            end
            S_HUNT: begin
                if (w_rx_s) w_seen_nx = 1'b1;
                if (r_seen && r_fall) begin
                    w_state_nx = S_MEAS;
                    w_total_nx = '0;
                    w_intv_nx  = '0;
                    w_edges_nx = 3'd1;
                end
            end
            S_MEAS: begin
                w_total_nx = w_tot;
                w_intv_nx  = w_int;
                // Timeout takes priority over a coincident fall
                if (w_tot == TMO_C) begin
                    w_state_nx = S_IDLE;
                    w_err_nx   = 1'b1;
                    w_code_nx  = 2'd1;
                end else if (r_fall) begin
                    w_edges_nx = r_edges + 3'd1;
                    w_intv_nx  = '0;
                    if (r_edges == 3'd1) begin
                        w_i0_nx = w_int;
                    end else if (w_bad) begin
                        w_state_nx = S_IDLE;
                        w_err_nx   = 1'b1;
                        w_code_nx  = 2'd2;
                    end else if (r_edges == 3'd4) begin
                        w_state_nx = S_IDLE;
                        if (w_div < MIN_DIV_C) begin
                            w_err_nx  = 1'b1;
                            w_code_nx = 2'd3;
                        end else begin
                            w_valid_nx = 1'b1;
                            w_div_nx   = w_div;
                        end
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_total <= '0;
            r_intv  <= '0;
            r_i0    <= '0;
            r_edges <= '0;
            r_seen  <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_code  <= '0;
            r_div   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_total <= w_total_nx;
            r_intv  <= w_intv_nx;
            r_i0    <= w_i0_nx;
            r_edges <= w_edges_nx;
            r_seen  <= w_seen_nx;
            r_valid <= w_valid_nx;
            r_err   <= w_err_nx;
            r_code  <= w_code_nx;
            r_div   <= w_div_nx;
        end
    end

    assign o_busy     = (r_state != S_IDLE);
    assign o_valid    = r_valid;
    assign o_err      = r_err;
    assign o_err_code = r_code;
    assign o_divisor  = r_div;
endmodule
